ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
// - EX->MEM boundary of the 5-stage RV32I pipeline: consumes ALU result/flags, resolves BEQ..BGEU/JAL/JALR,
//   registers the EX/MEM payload, issues a one-cycle fetch redirect and squashes wrong-path EX slots.
// - Sole owner of control-flow resolution; downstream MEM stage sees only the registered payload.
// PARAMETERS
// - XLEN          32  datapath width (only 32 supported)
// - SQUASH_SLOTS  1   EX-valid slots squashed after a redirect is issued (1..3)
// PORTS
// - clk           in   1     rising-edge clock
// - rst           in   1     synchronous, active-high reset
// - stall         in   1     MEM stage back-pressure; hold all registers
// - flush_in      in   1     external flush (trap/exception); kill EX/MEM slot
// - ex_valid      in   1     EX slot holds a real instruction
// - ex_pc         in   32    PC of EX instruction
// - ex_imm        in   32    sign-extended immediate
// - alu_r         in   32    ALU result (rs1+imm for JALR/loads/stores; rs1-rs2 for branches)
// - alu_cf/zf/vf/sf in 1 each ALU carry/zero/overflow/sign flags (from a+~b+1 for branches)
// - ex_branch, ex_jal, ex_jalr in 1 each  control-flow class (one-hot or none)
// - ex_funct3     in   3     branch condition / memory size
// - ex_rs2_data   in   32    store data
// - ex_rd         in   5     destination register
// - ex_reg_write, ex_mem_read, ex_mem_write in 1 each  control bits
// - ex_ready      out  1     stage accepts EX slot this cycle (= ~stall)
// - mem_valid     out  1     registered slot valid
// - mem_result    out  32    alu_r, or ex_pc+4 for JAL/JALR
// - mem_store_data out 32    registered ex_rs2_data
// - mem_rd        out  5 ; mem_funct3 out 3 ; mem_reg_write/mem_mem_read/mem_mem_write out 1 each
// - redirect      out  1     one-cycle pulse: fetch must load redirect_pc
// - redirect_pc   out  32    resolved target
// BEHAVIOUR
// - Reset: every output 0; FSM=RUN; squash counter 0. Reset mid-stall/mid-squash aborts all.
// - Priority per cycle: rst > flush_in > stall > normal capture.
// - Accept when ~stall: payload latched at next edge, latency 1 cycle. stall=1: all regs hold, redirect forced 0.
// - Taken: BEQ 000 zf; BNE 001 ~zf; BLT 100 sf!=vf; BGE 101 sf==vf; BLTU 110 ~cf; BGEU 111 cf;
//   010/011 never taken. JAL/JALR always taken.
// - Target: branch/JAL = ex_pc+ex_imm (mod 2^32, wraps); JALR = alu_r & ~32'h1.
// - mem_result: ex_pc+4 (wraps 0xFFFFFFFC->0) for JAL/JALR, else alu_r. Branches: mem_reg_write=0.
// - FSM RUN: accepted valid taken slot -> redirect=1 next cycle with redirect_pc, go SQUASH, cnt=SQUASH_SLOTS.
// - FSM SQUASH: each accepted ex_valid slot captured with mem_valid=0 and no redirect; cnt--; cnt==0 -> RUN.
//   Invalid slots (bubbles) do not decrement. stall freezes cnt.
// - flush_in: mem_valid<=0, redirect<=0, FSM<=RUN, cnt<=0 (even if stall=1).
// - ex_valid=0 accepted: mem_valid<=0, control bits <=0, no redirect.
// - Not-taken branch: mem_valid=1, no memory/reg side effects, no redirect.
// CONFIGURATION
// - BRANCH_STATS_EN defined: adds outputs stat_branches[31:0] (accepted valid non-squashed ex_branch)
//   and stat_taken[31:0] (those taken, plus JAL/JALR); saturate at 32'hFFFFFFFF; reset to 0; hold on stall.
// - Undefined: ports and counters absent; no other behaviour change.
// TESTING
// - BEQ pc=0x100 imm=0x20 zf=1 -> next cycle redirect=1, redirect_pc=0x120, mem_reg_write=0; next slot mem_valid=0.
// - BLTU cf=1 then BGEU cf=1 -> first not taken (redirect=0), second redirect_pc=pc+imm.
// - JALR pc=0x200 alu_r=0x1235 rd=1 -> mem_result=0x204, redirect_pc=0x1234, mem_reg_write=1.
// - JAL pc=0xFFFFFFFC imm=8 -> redirect_pc=0x4, mem_result=0x0 (wrap).
// - Taken branch, then stall=1 3 cycles with ex_valid=1 -> outputs held, redirect single pulse, first post-stall slot squashed.
// - flush_in=1 with stall=1 during SQUASH -> mem_valid=0, FSM RUN; next valid slot captured normally; rst mid-squash -> all 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ex_mem_stage: EX/MEM pipeline register with branch/jump resolution, one-cycle fetch redirect and
// wrong-path squash. Optional BRANCH_STATS_EN adds saturating branch statistics outputs. Rev 1.0
module ex_mem_stage #(
  parameter int XLEN         = 32,
  parameter int SQUASH_SLOTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush_in,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf,
  input  logic            alu_zf,
  input  logic            alu_vf,
  input  logic            alu_sf,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  output logic            ex_ready,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
`endif
);

  localparam logic [1:0] SQ_INIT = 2'(SQUASH_SLOTS);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_t;

  state_t          state, state_nx;
  logic [1:0]      cnt, cnt_nx;
  logic            cond_taken;
  logic            cf_taken;
  logic            squashing;
  logic            live;
  logic            issue;
  logic            is_jump;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;

  assign ex_ready = ~stall;

  always_comb begin
    cond_taken = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = alu_zf;
      3'b001:  cond_taken = ~alu_zf;
      3'b100:  cond_taken = alu_sf ^ alu_vf;
      3'b101:  cond_taken = ~(alu_sf ^ alu_vf);
      3'b110:  cond_taken = ~alu_cf;
      3'b111:  cond_taken = alu_cf;
      default: cond_taken = 1'b0;
    endcase
  end

  assign is_jump   = ex_jal | ex_jalr;
  assign cf_taken  = is_jump | (ex_branch & cond_taken);
  assign squashing = (state == ST_SQUASH);
  // live: a real, on-path instruction accepted this cycle
  assign live      = ~stall & ~flush_in & ex_valid & ~squashing;
  assign issue     = live & cf_taken;
  assign target    = ex_jalr ? (alu_r & ~32'h1) : (ex_pc + ex_imm);
  assign link      = ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush_in) begin
      state_nx = ST_RUN;
      cnt_nx   = 2'd0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (issue) begin
            state_nx = ST_SQUASH;
            cnt_nx   = SQ_INIT;
          end
        end
        ST_SQUASH: begin
          // bubbles do not consume a squash slot
          if (ex_valid) begin
            cnt_nx = cnt - 2'd1;
            if (cnt == 2'd1) state_nx = ST_RUN;
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= 5'd0;
      mem_funct3     <= 3'd0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush_in) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      redirect      <= 1'b0;
    end else if (stall) begin
      redirect <= 1'b0;
    end else begin
      mem_valid      <= ex_valid & ~squashing;
      mem_result     <= is_jump ? link : alu_r;
      mem_store_data <= ex_rs2_data;
      mem_rd         <= ex_rd;
      mem_funct3     <= ex_funct3;
      mem_reg_write  <= live & ex_reg_write & ~ex_branch;
      mem_mem_read   <= live & ex_mem_read & ~ex_branch;
      mem_mem_write  <= live & ex_mem_write & ~ex_branch;
      redirect       <= issue;
      if (issue) redirect_pc <= target;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= 32'd0;
      stat_taken    <= 32'd0;
    end else if (live) begin
      if (ex_branch && stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (cf_taken && stat_taken != 32'hFFFF_FFFF) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// tb_ex_mem_stage: directed vectors, operand-level reference model compared every cycle,
// plus literal expectations on key scenarios.
module tb_ex_mem_stage;
  localparam int SQ = 1;

  logic        clk = 1'b0;
  logic        rst, stall, flush_in, ex_valid;
  logic [31:0] ex_pc, ex_imm, alu_r, ex_rs2_data;
  logic        alu_cf, alu_zf, alu_vf, alu_sf, ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, redirect;
  logic [31:0] mem_result, mem_store_data, redirect_pc;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  logic [31:0] op_a, op_b;
  int          checks = 0;
  int          failures = 0;
  bit          started = 0;
  int          pulses;

  ex_mem_stage #(.XLEN(32), .SQUASH_SLOTS(SQ)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_in(flush_in), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .alu_r(alu_r),
    .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_funct3(ex_funct3),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Architectural branch decision straight from the operands.
  function automatic bit br_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model
  logic        e_valid, e_rw, e_mr, e_mw, e_redir;
  logic [31:0] e_result, e_sd, e_rpc;
  logic [4:0]  e_rd;
  logic [2:0]  e_f3;
  int          sq_left;
  longint      e_sb, e_st;
  bit          kill, live, take;

  always @(posedge clk) begin
    if (rst) begin
      e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_redir = 0;
      e_result = 0; e_sd = 0; e_rpc = 0; e_rd = 0; e_f3 = 0;
      sq_left = 0; e_sb = 0; e_st = 0;
    end else if (flush_in) begin
      e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_redir = 0; sq_left = 0;
    end else if (stall) begin
      e_redir = 0;
    end else begin
      kill = ex_valid && (sq_left > 0);
      live = ex_valid && !kill;
      take = ex_jal || ex_jalr || (ex_branch && br_taken(ex_funct3, op_a, op_b));
      e_valid  = live;
      e_result = (ex_jal || ex_jalr) ? 32'(ex_pc + 32'd4) : alu_r;
      e_sd = ex_rs2_data; e_rd = ex_rd; e_f3 = ex_funct3;
      e_rw = live && ex_reg_write && !ex_branch;
      e_mr = live && ex_mem_read && !ex_branch;
      e_mw = live && ex_mem_write && !ex_branch;
      e_redir = live && take;
      if (kill) sq_left--;
      if (e_redir) begin
        e_rpc = ex_jalr ? (alu_r & 32'hFFFF_FFFE) : 32'(ex_pc + ex_imm);
        sq_left = SQ;
      end
      if (live && ex_branch && e_sb < 64'hFFFF_FFFF) e_sb++;
      if (live && take && e_st < 64'hFFFF_FFFF) e_st++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ex_ready", ex_ready, !stall);
      chk("mem_valid", mem_valid, e_valid);
      chk("redirect", redirect, e_redir);
      chk("mem_reg_write", mem_reg_write, e_rw);
      chk("mem_mem_read", mem_mem_read, e_mr);
      chk("mem_mem_write", mem_mem_write, e_mw);
      if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
      if (e_valid) begin
        chk("mem_result", mem_result, e_result);
        chk("mem_store_data", mem_store_data, e_sd);
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_funct3", mem_funct3, e_f3);
      end
`ifdef BRANCH_STATS_EN
      chk("stat_branches", stat_branches, e_sb[31:0]);
      chk("stat_taken", stat_taken, e_st[31:0]);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    alu_cf = 0; alu_zf = 0; alu_vf = 0; alu_sf = 0;
    ex_funct3 = 0; ex_rd = 0; ex_imm = 0; ex_rs2_data = 0; alu_r = 0;
    op_a = 0; op_b = 0;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    clr();
    d = {1'b0, a} + {1'b0, ~b} + 33'd1;
    op_a = a; op_b = b;
    ex_valid = 1; ex_branch = 1; ex_reg_write = 1; ex_pc = pc; ex_imm = imm; ex_funct3 = f3;
    alu_r = d[31:0]; alu_cf = d[32]; alu_zf = (d[31:0] == 32'd0); alu_sf = d[31];
    alu_vf = (a[31] != b[31]) && (d[31] != a[31]);
    ex_rs2_data = b; ex_rd = 5'd7;
  endtask

  task automatic set_alu(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd);
    clr();
    ex_valid = 1; ex_reg_write = 1; ex_pc = pc; alu_r = res; ex_rd = rd;
  endtask

  task automatic set_jal(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    clr();
    ex_valid = 1; ex_jal = 1; ex_reg_write = 1; ex_pc = pc; ex_imm = imm; ex_rd = rd;
  endtask

  task automatic set_jalr(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd);
    clr();
    ex_valid = 1; ex_jalr = 1; ex_reg_write = 1; ex_pc = pc; alu_r = res; ex_rd = rd;
  endtask

  initial begin
    rst = 1; stall = 0; flush_in = 0; ex_pc = 0;
    clr();
    cyc();
    started = 1;
    cyc();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_mem_result", mem_result, 0);
    rst = 0;

    // BEQ taken, then one squashed slot
    set_br(32'h100, 32'h20, 3'd0, 32'd5, 32'd5); cyc();
    chk("beq_redirect", redirect, 1);
    chk("beq_target", redirect_pc, 32'h120);
    chk("beq_no_regwrite", mem_reg_write, 0);
    chk("beq_valid", mem_valid, 1);
    set_alu(32'h104, 32'h55, 5'd3); cyc();
    chk("beq_squash", mem_valid, 0);
    chk("beq_pulse_end", redirect, 0);
    set_alu(32'h120, 32'h66, 5'd4); cyc();
    chk("after_squash_valid", mem_valid, 1);
    chk("after_squash_result", mem_result, 32'h66);

    // BLTU not taken, BGEU taken (9 vs 3, cf=1)
    set_br(32'h300, 32'h40, 3'd6, 32'd9, 32'd3); cyc();
    chk("bltu_not_taken", redirect, 0);
    chk("bltu_valid", mem_valid, 1);
    set_br(32'h304, 32'h40, 3'd7, 32'd9, 32'd3); cyc();
    chk("bgeu_target", redirect_pc, 32'h344);
    clr(); cyc();                                 // bubble does not consume the squash slot
    set_alu(32'h308, 32'h1, 5'd2); cyc();
    chk("bgeu_squash", mem_valid, 0);
    set_alu(32'h344, 32'h2, 5'd2); cyc();

    // load / store payload
    clr(); ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; alu_r = 32'h800; ex_funct3 = 3'd2; ex_rd = 5'd9; cyc();
    clr(); ex_valid = 1; ex_mem_write = 1; alu_r = 32'h804; ex_rs2_data = 32'hDEADBEEF; ex_funct3 = 3'd2; cyc();
    chk("store_data", mem_store_data, 32'hDEADBEEF);

    // JALR
    set_jalr(32'h200, 32'h1235, 5'd1); cyc();
    chk("jalr_link", mem_result, 32'h204);
    chk("jalr_target", redirect_pc, 32'h1234);
    chk("jalr_regwrite", mem_reg_write, 1);
    set_alu(32'h204, 32'h9, 5'd5); cyc();

    // JAL with wrap
    set_jal(32'hFFFF_FFFC, 32'd8, 5'd1); cyc();
    chk("jal_target_wrap", redirect_pc, 32'h4);
    chk("jal_link_wrap", mem_result, 32'h0);
    set_alu(32'h0, 32'h9, 5'd5); cyc();

    // signed compares and never-taken encodings
    set_br(32'h500, 32'h10, 3'd4, 32'hFFFF_FFFF, 32'd1); cyc();   // BLT -1<1 taken
    chk("blt_target", redirect_pc, 32'h510);
    set_alu(32'h504, 32'h0, 5'd1); cyc();
    set_br(32'h510, 32'h10, 3'd5, 32'hFFFF_FFFF, 32'd1); cyc();   // BGE not taken
    chk("bge_not_taken", redirect, 0);
    set_br(32'h514, 32'h10, 3'd2, 32'd4, 32'd4); cyc();
    chk("f3_010_never", redirect, 0);
    set_br(32'h518, 32'h10, 3'd3, 32'd4, 32'd5); cyc();
    chk("f3_011_never", redirect, 0);
    set_br(32'h51C, 32'hFFFF_FFF0, 3'd1, 32'h8000_0000, 32'd1); cyc();  // BNE taken, backward
    chk("bne_target", redirect_pc, 32'h50C);
    set_alu(32'h520, 32'h0, 5'd1); cyc();

    // taken branch followed by three stall cycles
    set_br(32'h400, 32'h10, 3'd0, 32'd3, 32'd3); cyc();
    pulses = 32'(redirect);
    set_alu(32'h404, 32'h77, 5'd6); stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pulses += 32'(redirect);
      chk("stall_hold_valid", mem_valid, 1);
      chk("stall_hold_result", mem_result, 32'h0);
    end
    chk("single_pulse", pulses, 1);
    stall = 0; cyc();
    chk("post_stall_squash", mem_valid, 0);
    set_alu(32'h410, 32'h78, 5'd6); cyc();
    chk("post_stall_live", mem_valid, 1);

    // flush during squash with stall asserted
    set_jal(32'h600, 32'h100, 5'd1); cyc();
    set_alu(32'h604, 32'h11, 5'd2); stall = 1; flush_in = 1; cyc();
    chk("flush_valid", mem_valid, 0);
    chk("flush_redirect", redirect, 0);
    stall = 0; flush_in = 0; set_alu(32'h700, 32'h12, 5'd2); cyc();
    chk("flush_then_capture", mem_valid, 1);
    chk("flush_then_result", mem_result, 32'h12);

    // reset in the middle of a squash window
    set_br(32'h800, 32'h8, 3'd0, 32'd1, 32'd1); cyc();
    rst = 1; set_alu(32'h804, 32'h13, 5'd3); cyc();
    chk("rst_mid_valid", mem_valid, 0);
    chk("rst_mid_redirect", redirect, 0);
    chk("rst_mid_rpc", redirect_pc, 0);
    chk("rst_mid_result", mem_result, 0);
    rst = 0; cyc();
    chk("rst_then_capture", mem_valid, 1);
    clr(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
